bram_port_arbiter: RTL and testbench

Shares BRAM port A between the CR16 core and a second requester: the program loader or debug host. It grants the port to one requester per cycle, muxes address, write data and write enable onto the BRAM, and steers the one-cycle-late read data valid back to the requester that issued the read. A bounded burst quota keeps either side from starving the other. The block sits between `cr16` and `bram` in `cr16_top`; `O_CPU_STALL` drives the core's `I_ENABLE`.

---
 rtl/bram_port_arbiter_if.sv | 53 +++++
 rtl/bram_port_arbiter.sv | 102 ++++++++++
 tb/tb_bram_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Bus bundle for bram_port_arbiter: CPU and loader request ports, BRAM port A, grants and read valids.
// The I_LDR_LOCK member exists only when BRAM_ARB_LDR_LOCK_EN is defined.
interface bram_port_arbiter_if #(
    parameter int unsigned P_DATA_WIDTH    = 16,
    parameter int unsigned P_ADDRESS_WIDTH = 10
);
    logic                       cpu_req;
    logic [P_ADDRESS_WIDTH-1:0] cpu_address;
    logic [P_DATA_WIDTH-1:0]    cpu_data;
    logic                       cpu_write_enable;
    logic                       ldr_req;
    logic [P_ADDRESS_WIDTH-1:0] ldr_address;
    logic [P_DATA_WIDTH-1:0]    ldr_data;
    logic                       ldr_write_enable;
`ifdef BRAM_ARB_LDR_LOCK_EN
    logic                       ldr_lock;
`endif
    logic [P_DATA_WIDTH-1:0]    bram_rdata;
    logic [P_ADDRESS_WIDTH-1:0] bram_address;
    logic [P_DATA_WIDTH-1:0]    bram_data;
    logic                       bram_write_enable;
    logic                       cpu_gnt;
    logic                       ldr_gnt;
    logic                       cpu_stall;
    logic                       cpu_rvalid;
    logic                       ldr_rvalid;
    logic [P_DATA_WIDTH-1:0]    rdata;
    logic                       owner;

    modport slave (
`ifdef BRAM_ARB_LDR_LOCK_EN
        input  ldr_lock,
`endif
        input  cpu_req, cpu_address, cpu_data, cpu_write_enable,
        input  ldr_req, ldr_address, ldr_data, ldr_write_enable,
        input  bram_rdata,
        output bram_address, bram_data, bram_write_enable,
        output cpu_gnt, ldr_gnt, cpu_stall, cpu_rvalid, ldr_rvalid,
        output rdata, owner
    );

    modport master (
`ifdef BRAM_ARB_LDR_LOCK_EN
        output ldr_lock,
`endif
        output cpu_req, cpu_address, cpu_data, cpu_write_enable,
        output ldr_req, ldr_address, ldr_data, ldr_write_enable,
        output bram_rdata,
        input  bram_address, bram_data, bram_write_enable,
        input  cpu_gnt, ldr_gnt, cpu_stall, cpu_rvalid, ldr_rvalid,
        input  rdata, owner
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for BRAM port A (CR16 core vs loader/debug host) with a burst quota and
// read-valid steering. Optional loader lock enabled by defining BRAM_ARB_LDR_LOCK_EN.
module bram_port_arbiter #(
    parameter int unsigned P_DATA_WIDTH    = 16,
    parameter int unsigned P_ADDRESS_WIDTH = 10,
    parameter int unsigned P_BURST         = 4
) (
    input  logic                I_CLK,
    input  logic                I_NRESET,
    bram_port_arbiter_if.slave  bus_if
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_BURST - 1);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_LDR = 1'b1
    } owner_e;

    owner_e                     owner_q, owner_d;
    owner_e                     tag_q, tag_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       pend_q, pend_d;

    logic                       cur_req;
    logic                       oth_req;
    logic                       cur_we;
    logic [P_ADDRESS_WIDTH-1:0] cur_address;
    logic [P_DATA_WIDTH-1:0]    cur_data;
    logic                       lock_hold;
    logic                       quota_hit;

    // Owner-side selection; the non-owner never reaches the BRAM.
    always_comb begin : port_mux
        if (owner_q == OWNER_LDR) begin
            cur_req     = bus_if.ldr_req;
            oth_req     = bus_if.cpu_req;
            cur_we      = bus_if.ldr_write_enable;
            cur_address = bus_if.ldr_address;
            cur_data    = bus_if.ldr_data;
        end else begin
            cur_req     = bus_if.cpu_req;
            oth_req     = bus_if.ldr_req;
            cur_we      = bus_if.cpu_write_enable;
            cur_address = bus_if.cpu_address;
            cur_data    = bus_if.cpu_data;
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin : state_reg
        if (!I_NRESET) begin
            owner_q <= OWNER_CPU;
            tag_q   <= OWNER_CPU;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            tag_q   <= tag_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    // Next owner / quota counter / read tag. A beat is any cycle where the owner requests.
    always_comb begin : next_state
        owner_d   = owner_q;
        tag_d     = tag_q;
        count_d   = count_q;
        pend_d    = 1'b0;
        lock_hold = 1'b0;
`ifdef BRAM_ARB_LDR_LOCK_EN
        lock_hold = (owner_q == OWNER_LDR) && bus_if.ldr_lock;
`endif
        quota_hit = cur_req && (count_q == CNT_LAST) && !lock_hold;

        if (oth_req && (!cur_req || quota_hit)) begin
            owner_d = (owner_q == OWNER_CPU) ? OWNER_LDR : OWNER_CPU;
            count_d = '0;
        end else if (lock_hold) begin
            count_d = '0;
        end else if (cur_req && (count_q != CNT_LAST)) begin
            count_d = CNT_W'(count_q + 1'b1);
        end

        if (cur_req && !cur_we) begin
            pend_d = 1'b1;
            tag_d  = owner_q;
        end
    end

    assign bus_if.bram_address      = cur_address;
    assign bus_if.bram_data         = cur_data;
    assign bus_if.bram_write_enable = I_NRESET & cur_req & cur_we;

    assign bus_if.cpu_gnt    = (owner_q == OWNER_CPU);
    assign bus_if.ldr_gnt    = (owner_q == OWNER_LDR);
    assign bus_if.cpu_stall  = bus_if.cpu_req & (owner_q != OWNER_CPU);
    assign bus_if.cpu_rvalid = pend_q & (tag_q == OWNER_CPU);
    assign bus_if.ldr_rvalid = pend_q & (tag_q == OWNER_LDR);
    assign bus_if.rdata      = bus_if.bram_rdata;
    assign bus_if.owner      = owner_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural one-cycle-latency BRAM.
module tb_bram_port_arbiter;
    logic clk = 1'b0;
    logic nreset;
    int   n_tests = 0;
    int   n_fail  = 0;

    bram_port_arbiter_if #(.P_DATA_WIDTH(16), .P_ADDRESS_WIDTH(10)) bus_if ();

    bram_port_arbiter #(.P_DATA_WIDTH(16), .P_ADDRESS_WIDTH(10), .P_BURST(4)) dut (
        .I_CLK    (clk),
        .I_NRESET (nreset),
        .bus_if   (bus_if)
    );

    always #5 clk = ~clk;

    // BRAM model: preloaded with 0xA000 | address on the first edge, read data one cycle late.
    logic [15:0] mem [0:1023];
    logic [15:0] bram_q;
    bit          mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'hA000 | 16'(i);
            mem_ready <= 1'b1;
        end else begin
            if (bus_if.bram_write_enable) mem[bus_if.bram_address] <= bus_if.bram_data;
            bram_q <= mem[bus_if.bram_address];
        end
    end
    assign bus_if.bram_rdata = bram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_cpu;
        logic prev_cpu;

        nreset                  = 1'b0;
        bus_if.cpu_req          = 1'b1;
        bus_if.cpu_write_enable = 1'b1;
        bus_if.cpu_address      = 10'h3FF;
        bus_if.cpu_data         = 16'h5555;
        bus_if.ldr_req          = 1'b0;
        bus_if.ldr_write_enable = 1'b0;
        bus_if.ldr_address      = 10'h000;
        bus_if.ldr_data         = 16'h0000;
`ifdef BRAM_ARB_LDR_LOCK_EN
        bus_if.ldr_lock         = 1'b0;
`endif
        #2;
        chk("rst_cpu_gnt", 32'(bus_if.cpu_gnt), 32'd1);
        chk("rst_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd0);
        chk("rst_owner", 32'(bus_if.owner), 32'd0);
        chk("rst_we_forced", 32'(bus_if.bram_write_enable), 32'd0);
        chk("rst_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd0);
        chk("rst_ldr_rvalid", 32'(bus_if.ldr_rvalid), 32'd0);
        chk("rst_stall", 32'(bus_if.cpu_stall), 32'd0);
        bus_if.cpu_req          = 1'b0;
        bus_if.cpu_write_enable = 1'b0;
        #10 nreset = 1'b1;
        tick();

        // CPU only: back-to-back reads of 0x005..0x008
        for (int i = 0; i < 4; i++) begin
            bus_if.cpu_req     = 1'b1;
            bus_if.cpu_address = 10'(5 + i);
            #1;
            chk("cpu_only_gnt", 32'(bus_if.cpu_gnt), 32'd1);
            chk("cpu_only_stall", 32'(bus_if.cpu_stall), 32'd0);
            chk("cpu_only_addr", 32'(bus_if.bram_address), 32'(5 + i));
            if (i > 0) begin
                chk("cpu_only_rvalid", 32'(bus_if.cpu_rvalid), 32'd1);
                chk("cpu_only_ldr_rvalid", 32'(bus_if.ldr_rvalid), 32'd0);
                chk("cpu_only_rdata", 32'(bus_if.rdata), 32'hA000 + 32'(4 + i));
            end
            tick();
        end
        bus_if.cpu_req = 1'b0;
        #1;
        chk("cpu_only_last_rvalid", 32'(bus_if.cpu_rvalid), 32'd1);
        chk("cpu_only_last_rdata", 32'(bus_if.rdata), 32'hA008);
        tick();
        chk("cpu_only_rvalid_clear", 32'(bus_if.cpu_rvalid), 32'd0);

        // Loader takes an idle port and writes 0xBEEF to 0x010
        bus_if.ldr_req          = 1'b1;
        bus_if.ldr_write_enable = 1'b1;
        bus_if.ldr_address      = 10'h010;
        bus_if.ldr_data         = 16'hBEEF;
        #1;
        chk("ldr_idle_c0_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd0);
        chk("ldr_idle_c0_we", 32'(bus_if.bram_write_enable), 32'd0);
        tick();
        chk("ldr_idle_c1_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd1);
        chk("ldr_idle_c1_we", 32'(bus_if.bram_write_enable), 32'd1);
        chk("ldr_idle_c1_addr", 32'(bus_if.bram_address), 32'h010);
        chk("ldr_idle_c1_data", 32'(bus_if.bram_data), 32'hBEEF);
        chk("ldr_idle_c1_owner", 32'(bus_if.owner), 32'd1);
        tick();
        bus_if.ldr_req          = 1'b0;
        bus_if.ldr_write_enable = 1'b0;
        bus_if.cpu_req          = 1'b1;
        bus_if.cpu_address      = 10'h010;
        #1;
        chk("cpu_wait_stall", 32'(bus_if.cpu_stall), 32'd1);
        chk("cpu_wait_gnt", 32'(bus_if.cpu_gnt), 32'd0);
        tick();
        chk("cpu_switch_gnt", 32'(bus_if.cpu_gnt), 32'd1);
        chk("cpu_switch_stall", 32'(bus_if.cpu_stall), 32'd0);
        chk("cpu_switch_addr", 32'(bus_if.bram_address), 32'h010);
        tick();
        bus_if.cpu_req = 1'b0;
        #1;
        chk("raw_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd1);
        chk("raw_ldr_rvalid", 32'(bus_if.ldr_rvalid), 32'd0);
        chk("raw_rdata", 32'(bus_if.rdata), 32'hBEEF);
        tick();

        // Clean restart of the quota
        nreset = 1'b0;
        #1 nreset = 1'b1;

        // Both requesting continuously: CPU x4, LDR x4, CPU x4; CPU reads 0x003, loader reads 0x020
        bus_if.cpu_req          = 1'b1;
        bus_if.cpu_write_enable = 1'b0;
        bus_if.cpu_address      = 10'h003;
        bus_if.ldr_req          = 1'b1;
        bus_if.ldr_write_enable = 1'b0;
        bus_if.ldr_address      = 10'h020;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_cpu = (((k / 4) % 2) == 0);
            chk("both_cpu_gnt", 32'(bus_if.cpu_gnt), 32'(exp_cpu));
            chk("both_ldr_gnt", 32'(bus_if.ldr_gnt), 32'(!exp_cpu));
            chk("both_stall", 32'(bus_if.cpu_stall), 32'(!exp_cpu));
            chk("both_addr", 32'(bus_if.bram_address), exp_cpu ? 32'h003 : 32'h020);
            chk("both_we", 32'(bus_if.bram_write_enable), 32'd0);
            if (k == 0) begin
                chk("both_k0_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd0);
                chk("both_k0_ldr_rvalid", 32'(bus_if.ldr_rvalid), 32'd0);
            end else begin
                prev_cpu = ((((k - 1) / 4) % 2) == 0);
                chk("both_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'(prev_cpu));
                chk("both_ldr_rvalid", 32'(bus_if.ldr_rvalid), 32'(!prev_cpu));
                chk("both_rdata", 32'(bus_if.rdata), prev_cpu ? 32'hA003 : 32'hA020);
            end
            tick();
        end

        // Reset in the middle of a loader read burst (loader owns, count 0)
        for (int b = 0; b < 2; b++) begin
            #1;
            chk("mid_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd1);
            tick();
        end
        #1;
        chk("mid_b2_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd1);
        chk("mid_b2_ldr_rvalid", 32'(bus_if.ldr_rvalid), 32'd1);
        bus_if.cpu_write_enable = 1'b1;
        nreset = 1'b0;
        #1;
        chk("mid_rst_cpu_gnt", 32'(bus_if.cpu_gnt), 32'd1);
        chk("mid_rst_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd0);
        chk("mid_rst_owner", 32'(bus_if.owner), 32'd0);
        chk("mid_rst_we", 32'(bus_if.bram_write_enable), 32'd0);
        chk("mid_rst_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd0);
        chk("mid_rst_ldr_rvalid", 32'(bus_if.ldr_rvalid), 32'd0);
        bus_if.cpu_write_enable = 1'b0;
        nreset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("restart_cpu_gnt", 32'(bus_if.cpu_gnt), 32'(k < 4));
            chk("restart_ldr_gnt", 32'(bus_if.ldr_gnt), 32'(k >= 4));
            tick();
        end

`ifdef BRAM_ARB_LDR_LOCK_EN
        // Loader owns with LOCK held: quota suppressed for 10 beats while the CPU waits
        bus_if.ldr_lock = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("lock_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd1);
            chk("lock_cpu_stall", 32'(bus_if.cpu_stall), 32'd1);
            tick();
        end
        bus_if.ldr_lock = 1'b0;
        bus_if.ldr_req  = 1'b0;
        #1;
        chk("lock_drop_ldr_gnt", 32'(bus_if.ldr_gnt), 32'd1);
        tick();
        chk("lock_after_cpu_gnt", 32'(bus_if.cpu_gnt), 32'd1);
        chk("lock_after_stall", 32'(bus_if.cpu_stall), 32'd0);
`endif

        bus_if.cpu_req = 1'b0;
        bus_if.ldr_req = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
